// File: rtl/control_unit_br.sv
// SimpleCPU second-generation control unit: program counter, instruction register
// and controller FSM, with fetch wait states, LDI/SUB/JMPZ and HALT.
module control_unit_br #(
    parameter int unsigned PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     inst,
    input  logic            inst_valid,
    input  logic            rp_zero,
    output logic [PC_W-1:0] progcntr,
    output logic            fetch,
    output logic [7:0]      D_addr,
    output logic            D_rd,
    output logic            D_wr,
    output logic [1:0]      RF_s,
    output logic [7:0]      RF_W_data,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_wr,
    output logic [3:0]      RF_Rp_addr,
    output logic            RF_Rp_rd,
    output logic [3:0]      RF_Rq_addr,
    output logic            RF_Rq_rd,
    output logic [1:0]      alu_s,
    output logic            halted
);

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_LOAD   = 4'd3;
    localparam logic [3:0] S_STORE  = 4'd4;
    localparam logic [3:0] S_ADD    = 4'd5;
    localparam logic [3:0] S_SUB    = 4'd6;
    localparam logic [3:0] S_LDI    = 4'd7;
    localparam logic [3:0] S_JMPZ   = 4'd8;
    localparam logic [3:0] S_JMP    = 4'd9;
    localparam logic [3:0] S_HALT   = 4'd10;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LDI   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_JMPZ  = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [3:0]      state;
    logic [3:0]      state_nxt;
    logic [15:0]     ir;
    logic [PC_W-1:0] pc_nxt;
    logic [15:0]     ir_nxt;

    logic [3:0]      op;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [3:0]      rc;
    logic [7:0]      d;
    logic [PC_W-1:0] off_ext;

    assign op      = ir[15:12];
    assign ra      = ir[11:8];
    assign rb      = ir[7:4];
    assign rc      = ir[3:0];
    assign d       = ir[7:0];
    assign off_ext = {{(PC_W-8){ir[7]}}, ir[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT;
            progcntr <= RESET_VEC;
            ir       <= '0;
        end else begin
            state    <= state_nxt;
            progcntr <= pc_nxt;
            ir       <= ir_nxt;
        end
    end

    // PC already points past the JMPZ, so the -1 lands the target on JMPZ address + off.
    always_comb begin
        state_nxt = state;
        pc_nxt    = progcntr;
        ir_nxt    = ir;
        case (state)
            S_INIT: begin
                pc_nxt    = RESET_VEC;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (inst_valid) begin
                    ir_nxt    = inst;
                    pc_nxt    = progcntr + PC_ONE;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD:  state_nxt = S_LOAD;
                    OP_STORE: state_nxt = S_STORE;
                    OP_ADD:   state_nxt = S_ADD;
                    OP_LDI:   state_nxt = S_LDI;
                    OP_SUB:   state_nxt = S_SUB;
                    OP_JMPZ:  state_nxt = S_JMPZ;
                    OP_HALT:  state_nxt = S_HALT;
                    default:  state_nxt = S_FETCH;
                endcase
            end
            S_LOAD, S_STORE, S_ADD, S_SUB, S_LDI: state_nxt = S_FETCH;
            S_JMPZ: state_nxt = rp_zero ? S_JMP : S_FETCH;
            S_JMP: begin
                pc_nxt    = progcntr + off_ext - PC_ONE;
                state_nxt = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        fetch      = 1'b0;
        D_addr     = '0;
        D_rd       = 1'b0;
        D_wr       = 1'b0;
        RF_s       = 2'b00;
        RF_W_data  = '0;
        RF_W_addr  = '0;
        RF_W_wr    = 1'b0;
        RF_Rp_addr = '0;
        RF_Rp_rd   = 1'b0;
        RF_Rq_addr = '0;
        RF_Rq_rd   = 1'b0;
        alu_s      = 2'b00;
        halted     = 1'b0;
        case (state)
            S_FETCH: fetch = 1'b1;
            S_LOAD: begin
                D_addr    = d;
                D_rd      = 1'b1;
                RF_s      = 2'b01;
                RF_W_addr = ra;
                RF_W_wr   = 1'b1;
            end
            S_STORE: begin
                D_addr     = d;
                D_wr       = 1'b1;
                RF_Rp_addr = ra;
                RF_Rp_rd   = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Rp_addr = rb;
                RF_Rp_rd   = 1'b1;
                RF_Rq_addr = rc;
                RF_Rq_rd   = 1'b1;
                RF_s       = 2'b00;
                RF_W_addr  = ra;
                RF_W_wr    = 1'b1;
                alu_s      = (state == S_ADD) ? 2'b01 : 2'b10;
            end
            S_LDI: begin
                RF_s      = 2'b10;
                RF_W_data = d;
                RF_W_addr = ra;
                RF_W_wr   = 1'b1;
            end
            S_JMPZ: begin
                RF_Rp_addr = ra;
                RF_Rp_rd   = 1'b1;
                alu_s      = 2'b00;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit_br.sv
// Directed bench for control_unit_br: per-cycle expected outputs are queued by the
// stimulus process and compared by an independent monitor half a cycle later.
module tb_control_unit_br;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst;
    logic        inst_valid;
    logic        rp_zero;
    logic [15:0] progcntr;
    logic        fetch;
    logic [7:0]  D_addr;
    logic        D_rd;
    logic        D_wr;
    logic [1:0]  RF_s;
    logic [7:0]  RF_W_data;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Rp_addr;
    logic        RF_Rp_rd;
    logic [3:0]  RF_Rq_addr;
    logic        RF_Rq_rd;
    logic [1:0]  alu_s;
    logic        halted;

    control_unit_br #(.PC_W(16), .RESET_VEC(16'h0000)) dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .rp_zero(rp_zero),
        .progcntr(progcntr), .fetch(fetch), .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr),
        .RF_s(RF_s), .RF_W_data(RF_W_data), .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
        .RF_Rp_addr(RF_Rp_addr), .RF_Rp_rd(RF_Rp_rd), .RF_Rq_addr(RF_Rq_addr),
        .RF_Rq_rd(RF_Rq_rd), .alu_s(alu_s), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic        fetch;
        logic [7:0]  d_addr;
        logic        d_rd;
        logic        d_wr;
        logic [1:0]  rf_s;
        logic [7:0]  w_data;
        logic [3:0]  w_addr;
        logic        w_wr;
        logic [3:0]  rp_addr;
        logic        rp_rd;
        logic [3:0]  rq_addr;
        logic        rq_rd;
        logic [1:0]  alu;
        logic        halted;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic obs_t z(input logic [15:0] pc);
        obs_t e;
        e    = '0;
        e.pc = pc;
        return e;
    endfunction

    function automatic obs_t f(input logic [15:0] pc);
        obs_t e;
        e       = z(pc);
        e.fetch = 1'b1;
        return e;
    endfunction

    task automatic push(input string n, input obs_t e);
        item_t it;
        it.name = n;
        it.exp  = e;
        q.push_back(it);
    endtask

    // Monitor samples 1 time unit after each falling edge, well away from the active edge.
    initial begin
        item_t it;
        obs_t  act;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() != 0) begin
                it  = q.pop_front();
                act = {progcntr, fetch, D_addr, D_rd, D_wr, RF_s, RF_W_data, RF_W_addr,
                       RF_W_wr, RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, alu_s, halted};
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got pc=%h f=%b da=%h rd=%b wr=%b s=%b wd=%h wa=%h ww=%b pa=%h pr=%b qa=%h qr=%b alu=%b h=%b ; expected pc=%h f=%b da=%h rd=%b wr=%b s=%b wd=%h wa=%h ww=%b pa=%h pr=%b qa=%h qr=%b alu=%b h=%b",
                        it.name, act.pc, act.fetch, act.d_addr, act.d_rd, act.d_wr, act.rf_s, act.w_data,
                        act.w_addr, act.w_wr, act.rp_addr, act.rp_rd, act.rq_addr, act.rq_rd, act.alu, act.halted,
                        it.exp.pc, it.exp.fetch, it.exp.d_addr, it.exp.d_rd, it.exp.d_wr, it.exp.rf_s, it.exp.w_data,
                        it.exp.w_addr, it.exp.w_wr, it.exp.rp_addr, it.exp.rp_rd, it.exp.rq_addr, it.exp.rq_rd,
                        it.exp.alu, it.exp.halted);
                end
            end
        end
    end

    initial begin
        obs_t e;
        int   guard;
        rst = 1'b1; inst = 16'h0000; inst_valid = 1'b0; rp_zero = 1'b0;
        repeat (2) @(negedge clk);

        // Reset then LDI rA,5
        push("init", z(16'h0000));
        rst = 1'b0; inst_valid = 1'b1; inst = 16'h3A05;
        @(negedge clk); push("fetch_ldi", f(16'h0000));
        @(negedge clk); push("decode_ldi", z(16'h0001));
        @(negedge clk);
        e = z(16'h0001); e.rf_s = 2'b10; e.w_data = 8'h05; e.w_addr = 4'hA; e.w_wr = 1'b1;
        push("ldi", e);

        // Three wait states; a non-valid word on inst must not be taken
        @(negedge clk); push("fetch_w0", f(16'h0001)); inst_valid = 1'b0; inst = 16'h3B07;
        @(negedge clk); push("fetch_w1", f(16'h0001));
        @(negedge clk); push("fetch_w2", f(16'h0001));
        @(negedge clk); push("fetch_w3", f(16'h0001)); inst_valid = 1'b1; inst = 16'h0110;
        @(negedge clk); push("decode_load", z(16'h0002));
        @(negedge clk);
        e = z(16'h0002); e.d_addr = 8'h10; e.d_rd = 1'b1; e.rf_s = 2'b01; e.w_addr = 4'h1; e.w_wr = 1'b1;
        push("load", e); inst = 16'h1220;

        @(negedge clk); push("fetch_store", f(16'h0002));
        @(negedge clk); push("decode_store", z(16'h0003));
        @(negedge clk);
        e = z(16'h0003); e.d_addr = 8'h20; e.d_wr = 1'b1; e.rp_addr = 4'h2; e.rp_rd = 1'b1;
        push("store", e); inst = 16'h2345;

        @(negedge clk); push("fetch_add", f(16'h0003));
        @(negedge clk); push("decode_add", z(16'h0004));
        @(negedge clk);
        e = z(16'h0004); e.rp_addr = 4'h4; e.rp_rd = 1'b1; e.rq_addr = 4'h5; e.rq_rd = 1'b1;
        e.w_addr = 4'h3; e.w_wr = 1'b1; e.alu = 2'b01;
        push("add", e); inst = 16'h4345;

        @(negedge clk); push("fetch_sub", f(16'h0004));
        @(negedge clk); push("decode_sub", z(16'h0005));
        @(negedge clk);
        e = z(16'h0005); e.rp_addr = 4'h4; e.rp_rd = 1'b1; e.rq_addr = 4'h5; e.rq_rd = 1'b1;
        e.w_addr = 4'h3; e.w_wr = 1'b1; e.alu = 2'b10;
        push("sub", e); inst = 16'h57FD; rp_zero = 1'b1;

        // Taken JMPZ at PC=5, off=-3 -> 2
        @(negedge clk); push("fetch_jmpz_t", f(16'h0005));
        @(negedge clk); push("decode_jmpz_t", z(16'h0006));
        @(negedge clk);
        e = z(16'h0006); e.rp_addr = 4'h7; e.rp_rd = 1'b1;
        push("jmpz_t", e);
        @(negedge clk); push("jmp", z(16'h0006)); inst = 16'h6000; rp_zero = 1'b0;
        @(negedge clk); push("fetch_after_jmp", f(16'h0002));

        // NOPs walk PC from 2 to 5
        @(negedge clk); push("decode_nop0", z(16'h0003));
        @(negedge clk); push("fetch_nop1", f(16'h0003)); inst = 16'hE123;
        @(negedge clk); push("decode_nop1", z(16'h0004));
        @(negedge clk); push("fetch_nop2", f(16'h0004));
        @(negedge clk); push("decode_nop2", z(16'h0005)); inst = 16'h57FD;

        // Untaken JMPZ at PC=5
        @(negedge clk); push("fetch_jmpz_n", f(16'h0005));
        @(negedge clk); push("decode_jmpz_n", z(16'h0006));
        @(negedge clk);
        e = z(16'h0006); e.rp_addr = 4'h7; e.rp_rd = 1'b1;
        push("jmpz_n", e);
        @(negedge clk); push("fetch_after_nojmp", f(16'h0006)); inst_valid = 1'b0; inst = 16'hF000;

        // Reset during a pending fetch, asserted on an edge where inst_valid is also high
        @(negedge clk); push("fetch_wait_rst", f(16'h0006)); rst = 1'b1; inst_valid = 1'b1;
        @(negedge clk); push("init_after_rst", z(16'h0000)); rst = 1'b0; inst = 16'h50FF; rp_zero = 1'b1;

        // JMPZ at PC=0 with off=-1 wraps to 0xFFFF
        @(negedge clk); push("fetch_wrap", f(16'h0000));
        @(negedge clk); push("decode_wrap", z(16'h0001));
        @(negedge clk);
        e = z(16'h0001); e.rp_addr = 4'h0; e.rp_rd = 1'b1;
        push("jmpz_wrap", e);
        @(negedge clk); push("jmp_wrap", z(16'h0001)); inst = 16'hF000;
        @(negedge clk); push("fetch_wrap_pc", f(16'hFFFF));

        // HALT fetched at 0xFFFF; PC increment wraps to 0
        @(negedge clk); push("decode_halt", z(16'h0000));
        e = z(16'h0000); e.halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); push($sformatf("halt_%0d", i), e);
        end
        rst = 1'b1;
        @(negedge clk); push("init_after_halt", z(16'h0000)); rst = 1'b0;
        @(negedge clk); push("fetch_after_halt", f(16'h0000));

        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit_br.md
Name: control_unit_br

Overview:
- Second-generation SimpleCPU control unit. It holds the program counter, the instruction register and the controller FSM in one block.
- Compared with the v1 load/store/add unit it adds:
  - a parametrised PC width and reset vector;
  - a wait-state handshake on instruction fetch;
  - load-constant, subtract and jump-if-zero instructions;
  - a halt instruction.
- It sits between the instruction memory and the datapath (data memory, register file, ALU).

Parameters:
- PC_W, 16, program counter width in bits.
- RESET_VEC, 0, PC value loaded on reset and in INIT (PC_W bits).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- inst  in  16  instruction memory read data.
- inst_valid  in  1  inst is valid this cycle; this completes the fetch.
- rp_zero  in  1  datapath flag: the value read on the Rp port is zero.
- progcntr  out  PC_W  program counter; used as the instruction address.
- fetch  out  1  instruction memory read request.
- D_addr  out  8  data memory address.
- D_rd  out  1  data memory read.
- D_wr  out  1  data memory write.
- RF_s  out  2  register-file write mux select: 00 ALU, 01 data memory, 10 constant.
- RF_W_data  out  8  constant for load-immediate, equal to IR[7:0].
- RF_W_addr  out  4  register-file write address.
- RF_W_wr  out  1  register-file write enable.
- RF_Rp_addr  out  4  Rp read address.
- RF_Rp_rd  out  1  Rp read enable.
- RF_Rq_addr  out  4  Rq read address.
- RF_Rq_rd  out  1  Rq read enable.
- alu_s  out  2  ALU op: 00 pass, 01 add, 10 sub.
- halted  out  1  high while the FSM is in HALT.

Behaviour:
- Reset and clocking:
  - Reset clk, rst, synchronous, active-high.
  - On reset: state=INIT, progcntr=RESET_VEC, IR=0.
  - All control outputs are Moore-decoded from the state and IR. In INIT every output except progcntr is 0.
- Instruction fields:
  - op=IR[15:12], ra=IR[11:8], rb=IR[7:4], rc=IR[3:0], d=IR[7:0].
  - off=IR[7:0], signed two's complement.
- Opcodes:
  - 0000 LOAD ra<=M[d]
  - 0001 STORE M[d]<=ra
  - 0010 ADD ra<=rb+rc
  - 0011 LDI ra<=d
  - 0100 SUB ra<=rb-rc
  - 0101 JMPZ if ra==0 jump by off
  - 1111 HALT
  - 0110-1110 NOP
- INIT: progcntr<=RESET_VEC. Next state is FETCH.
- FETCH:
  - fetch=1 every cycle in this state.
  - When inst_valid=1: IR<=inst, progcntr<=progcntr+1, next state is DECODE.
  - When inst_valid=0: stay in FETCH with PC and IR unchanged. Wait states are unbounded.
- DECODE: all outputs 0. Branch on op to the execute state; NOP opcodes return to FETCH.
- Execute states (one cycle each, then FETCH unless noted):
  - LOAD: D_addr=d, D_rd=1, RF_s=01, RF_W_addr=ra, RF_W_wr=1.
  - STORE: D_addr=d, D_wr=1, RF_Rp_addr=ra, RF_Rp_rd=1.
  - ADD or SUB: RF_Rp_addr=rb, RF_Rp_rd=1, RF_Rq_addr=rc, RF_Rq_rd=1, RF_s=00, RF_W_addr=ra, RF_W_wr=1. alu_s=01 for ADD, 10 for SUB.
  - LDI: RF_s=10, RF_W_data=d, RF_W_addr=ra, RF_W_wr=1.
  - JMPZ: RF_Rp_addr=ra, RF_Rp_rd=1, alu_s=00. rp_zero is sampled at the end of this cycle; 1 goes to JMP, 0 goes to FETCH.
  - JMP: progcntr<=progcntr+sext(off)-1, so the target is the JMPZ address plus off. Arithmetic is modulo 2^PC_W, with wrap-around in both directions. Next state is FETCH.
  - HALT: halted=1, no other outputs asserted. Stays in HALT until rst.
- When not written as above, progcntr and IR hold their value.
- Outputs not listed for a state are 0.
- Address fields of non-enabled ports are 0.
- rst in any state, including mid-fetch with a wait pending, wins over every other action on that edge.
- Latency:
  - Non-jump instructions take 3 cycles plus fetch wait states.
  - A taken JMPZ takes 4 cycles; an untaken JMPZ takes 3.

Test Plan:
- Reset then fetch: rst 1 cycle, inst_valid=1 always, inst=0x3A05 (LDI rA,5).
  - Required: INIT, then FETCH, then DECODE, then LDI.
  - Required outputs in LDI: RF_W_addr=A, RF_W_data=0x05, RF_s=10, RF_W_wr=1; progcntr goes 0 to 1.
- Fetch wait states: inst_valid low for 3 cycles in FETCH.
  - Required: fetch=1 for 4 cycles; progcntr and IR unchanged until inst_valid=1.
- Instruction sequence 0x0110 (LOAD r1,0x10), 0x1220 (STORE r2,0x20), 0x2345 (ADD), 0x4345 (SUB).
  - Required: D_rd/D_wr/RF_* exactly per state.
  - Required: alu_s=01 for ADD and 10 for SUB, with Rp=4, Rq=5, W=3.
- JMPZ at PC=5, inst=0x57FD (off=-3):
  - with rp_zero=1, progcntr=2 at the next FETCH;
  - with rp_zero=0, progcntr=6.
- JMPZ at PC=0 with off=-1 and PC_W=16: progcntr=0xFFFF, checking wrap-around.
- HALT (0xF000): halted=1 held for 20 cycles with no fetch; then rst, giving progcntr=RESET_VEC and halted=0.
